// File: rtl/gps_corr_pkg.sv
// Shared constants and saturation helpers for the GPS correlator.
// Sign encoding: bit value 0 stands for +1 and bit value 1 stands for -1.
package gps_corr_pkg;

  localparam logic POS = 1'b0;
  localparam logic NEG = 1'b1;

  localparam int ACC_W_DEF    = 16;
  localparam int CNT_W_DEF    = 15;
  localparam int EL_DELAY_DEF = 8;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/gps_correlator_arm.sv
// One correlator arm: integrates +/-1 products with saturation, restarts on
// an epoch sample and captures the finished period's total into its dump register.
module corr_arm
  import gps_corr_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             epoch,
  input  logic             prod,
  output logic [ACC_W-1:0] total
);

  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN = ACC_W'(sat_min(ACC_W));
  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] contrib;

  // Pinned at the rails instead of wrapping, so a strong signal never flips sign.
  always_comb begin
    contrib  = (prod == POS) ? ONE : -ONE;
    acc_next = acc;
    if ((prod == POS) && (acc != MAX)) begin
      acc_next = acc + ONE;
    end else if ((prod == NEG) && (acc != MIN)) begin
      acc_next = acc - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      total <= '0;
    end else if (valid) begin
      if (epoch) begin
        total <= acc;
        acc   <= contrib;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/gps_correlator.sv
// GPS I/Q correlator: carrier and code wipe-off, integrate-and-dump per code epoch.
// Define GPS_CORR_EARLY_LATE_EN to add early and late arms around a delayed prompt.
module gps_correlator
  import gps_corr_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EL_DELAY = EL_DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             if_sign,
  input  logic             lo_sin,
  input  logic             lo_cos,
  input  logic             code_chip,
  input  logic             epoch,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] acc_q,
  output logic [CNT_W-1:0] dump_count,
  output logic             overrun
`ifdef GPS_CORR_EARLY_LATE_EN
  ,
  output logic [ACC_W-1:0] acc_ie,
  output logic [ACC_W-1:0] acc_qe,
  output logic [ACC_W-1:0] acc_il,
  output logic [ACC_W-1:0] acc_ql
`endif
);

  if (EL_DELAY < 1) begin : g_bad_el_delay
    $error("EL_DELAY must be at least 1");
  end

  logic prompt_chip;
  logic pi_r, pq_r, valid_r, epoch_r;
  logic [CNT_W-1:0] count;

`ifdef GPS_CORR_EARLY_LATE_EN
  logic [2*EL_DELAY-1:0] code_line;
  logic                  pie_r, pqe_r, pil_r, pql_r;

  // The code history advances only on real samples so replica spacing is in samples, not cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_line <= '0;
    end else if (sample_valid) begin
      code_line <= {code_line[2*EL_DELAY-2:0], code_chip};
    end
  end

  assign prompt_chip = code_line[EL_DELAY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pie_r <= 1'b0;
      pqe_r <= 1'b0;
      pil_r <= 1'b0;
      pql_r <= 1'b0;
    end else begin
      pie_r <= if_sign ^ lo_cos ^ code_chip;
      pqe_r <= if_sign ^ lo_sin ^ code_chip;
      pil_r <= if_sign ^ lo_cos ^ code_line[2*EL_DELAY-1];
      pql_r <= if_sign ^ lo_sin ^ code_line[2*EL_DELAY-1];
    end
  end

  corr_arm #(.ACC_W(ACC_W)) u_arm_ie (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pie_r), .total(acc_ie));
  corr_arm #(.ACC_W(ACC_W)) u_arm_qe (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pqe_r), .total(acc_qe));
  corr_arm #(.ACC_W(ACC_W)) u_arm_il (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pil_r), .total(acc_il));
  corr_arm #(.ACC_W(ACC_W)) u_arm_ql (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pql_r), .total(acc_ql));
`else
  assign prompt_chip = code_chip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pi_r    <= 1'b0;
      pq_r    <= 1'b0;
      valid_r <= 1'b0;
      epoch_r <= 1'b0;
    end else begin
      pi_r    <= if_sign ^ lo_cos ^ prompt_chip;
      pq_r    <= if_sign ^ lo_sin ^ prompt_chip;
      valid_r <= sample_valid;
      epoch_r <= epoch & sample_valid;
    end
  end

  corr_arm #(.ACC_W(ACC_W)) u_arm_i (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pi_r), .total(acc_i));
  corr_arm #(.ACC_W(ACC_W)) u_arm_q (.clk(clk), .rst(rst), .valid(valid_r), .epoch(epoch_r), .prod(pq_r), .total(acc_q));

  // A dump landing on the same edge as an accept keeps dump_valid high and is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      dump_count <= '0;
      dump_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (valid_r) begin
        if (epoch_r) begin
          count <= CNT_W'(1);
        end else if (count != '1) begin
          count <= count + CNT_W'(1);
        end
      end
      if (valid_r && epoch_r) begin
        dump_count <= count;
        dump_valid <= 1'b1;
        if (dump_valid && !dump_ready) begin
          overrun <= 1'b1;
        end
      end else if (dump_valid && dump_ready) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gps_correlator.sv
// Scoreboard bench for gps_correlator: a 16-bit and an 8-bit instance share stimulus.
// A behavioural model predicts each dump and queues it with the cycle it must appear.
module tb_gps_correlator;

  localparam int CNT_W = 15;

  logic clk = 1'b0;
  logic rst, rst_req;
  logic sample_valid, if_sign, lo_sin, lo_cos, code_chip, epoch, dump_ready;

  logic             dump_valid, overrun;
  logic [15:0]      acc_i, acc_q;
  logic [CNT_W-1:0] dump_count;
  logic             n_dump_valid, n_overrun;
  logic [7:0]       n_acc_i, n_acc_q;
  logic [CNT_W-1:0] n_dump_count;
`ifdef GPS_CORR_EARLY_LATE_EN
  logic [15:0] acc_ie, acc_qe, acc_il, acc_ql;
  logic [7:0]  n_acc_ie, n_acc_qe, n_acc_il, n_acc_ql;
`endif

  gps_correlator dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .if_sign(if_sign),
    .lo_sin(lo_sin), .lo_cos(lo_cos), .code_chip(code_chip), .epoch(epoch),
    .dump_ready(dump_ready), .dump_valid(dump_valid), .acc_i(acc_i), .acc_q(acc_q),
    .dump_count(dump_count), .overrun(overrun)
`ifdef GPS_CORR_EARLY_LATE_EN
    , .acc_ie(acc_ie), .acc_qe(acc_qe), .acc_il(acc_il), .acc_ql(acc_ql)
`endif
  );

  gps_correlator #(.ACC_W(8)) dut_n (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .if_sign(if_sign),
    .lo_sin(lo_sin), .lo_cos(lo_cos), .code_chip(code_chip), .epoch(epoch),
    .dump_ready(dump_ready), .dump_valid(n_dump_valid), .acc_i(n_acc_i), .acc_q(n_acc_q),
    .dump_count(n_dump_count), .overrun(n_overrun)
`ifdef GPS_CORR_EARLY_LATE_EN
    , .acc_ie(n_acc_ie), .acc_qe(n_acc_qe), .acc_il(n_acc_il), .acc_ql(n_acc_ql)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int i_w;
    int q_w;
    int cnt;
    int i_n;
    int q_n;
  } dump_t;

  dump_t sb[$];
  int cyc, errors, checks;
  int m_i_w, m_q_w, m_i_n, m_q_n, m_cnt;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampStep(input int v, input int c, input int w);
    int r;
    r = v + c;
    if (r > (1 << (w - 1)) - 1) r = (1 << (w - 1)) - 1;
    if (r < -(1 << (w - 1))) r = -(1 << (w - 1));
    return r;
  endfunction

  task automatic checkDue();
    dump_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checkOutput("dump_valid", dump_valid, 1);
      checkOutput("acc_i", $signed(acc_i), e.i_w);
      checkOutput("acc_q", $signed(acc_q), e.q_w);
      checkOutput("dump_count", dump_count, e.cnt);
      checkOutput("n_dump_valid", n_dump_valid, 1);
      checkOutput("n_acc_i", $signed(n_acc_i), e.i_n);
      checkOutput("n_acc_q", $signed(n_acc_q), e.q_n);
      checkOutput("n_dump_count", n_dump_count, e.cnt);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic ifs, input logic sn, input logic cs,
                               input logic ch, input logic ep, input logic rdy);
    int ci, cq;
    @(negedge clk);
    cyc++;
    checkDue();
    rst          = rst_req;
    sample_valid = v;
    if_sign      = ifs;
    lo_sin       = sn;
    lo_cos       = cs;
    code_chip    = ch;
    epoch        = ep;
    dump_ready   = rdy;
    if (rst_req) begin
      checkOutput("sb_empty_at_reset", sb.size(), 0);
      sb.delete();
      m_i_w = 0; m_q_w = 0; m_i_n = 0; m_q_n = 0; m_cnt = 0;
    end else if (v) begin
      ci = (ifs ^ cs ^ ch) ? -1 : 1;
      cq = (ifs ^ sn ^ ch) ? -1 : 1;
      if (ep) begin
        sb.push_back('{cyc + 2, m_i_w, m_q_w, m_cnt, m_i_n, m_q_n});
        m_i_w = ci; m_q_w = cq; m_i_n = ci; m_q_n = cq; m_cnt = 1;
      end else begin
        m_i_w = clampStep(m_i_w, ci, 16);
        m_q_w = clampStep(m_q_w, cq, 16);
        m_i_n = clampStep(m_i_n, ci, 8);
        m_q_n = clampStep(m_q_n, cq, 8);
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  task automatic resetDut();
    rst_req = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_req = 1'b1;
    sample_valid = 0; if_sign = 0; lo_sin = 0; lo_cos = 0; code_chip = 0; epoch = 0; dump_ready = 0;
    cyc = 0; errors = 0; checks = 0;
    m_i_w = 0; m_q_w = 0; m_i_n = 0; m_q_n = 0; m_cnt = 0;

    resetDut();
    checkOutput("rst_dump_valid", dump_valid, 0);
    checkOutput("rst_acc_i", $signed(acc_i), 0);
    checkOutput("rst_acc_q", $signed(acc_q), 0);
    checkOutput("rst_dump_count", dump_count, 0);
    checkOutput("rst_overrun", overrun, 0);

    // 1000 samples of +1 on I and -1 on Q; the 8-bit instance pins at its rails.
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 999; k++) applyStimulus(1, 0, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    checkOutput("dv_one_cycle_after_epoch", dump_valid, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);

    // Alternate valid cycles with an alternating IF sign; one epoch lands on an invalid cycle.
    for (int i = 0; i < 400; i++)
      applyStimulus(logic'(i % 2 == 0), logic'((i / 2) % 2), 1, 0, 0, logic'(i == 0 || i == 101), 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);

    // Back-to-back epochs: a new dump coincides with an accept.
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 0, 0, 1);
    checkOutput("no_overrun_same_edge", overrun, 0);

    // Consumer stalls across further epochs.
    applyStimulus(1, 0, 1, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      if (k == 1) checkOutput("first_stalled_dump_no_overrun", overrun, 0);
    end
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("overrun_set", overrun, 1);
    checkOutput("dv_held_while_stalled", dump_valid, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("dv_cleared_by_accept", dump_valid, 0);
    checkOutput("overrun_sticky", overrun, 1);

    // Reset mid-integration discards the partial period.
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 499; k++) applyStimulus(1, 0, 1, 0, 0, 0, 1);
    resetDut();
    checkOutput("rst2_overrun", overrun, 0);
    checkOutput("rst2_dump_valid", dump_valid, 0);
    checkOutput("rst2_acc_i", $signed(acc_i), 0);
    for (int k = 0; k < 100; k++) applyStimulus(1, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);

    // Single -1 chip at the start of a 40-sample period.
    resetDut();
    applyStimulus(1, 0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 39; k++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
`ifdef GPS_CORR_EARLY_LATE_EN
    checkOutput("acc_ie", $signed(acc_ie), 38);
    checkOutput("acc_qe", $signed(acc_qe), 38);
    checkOutput("acc_il", $signed(acc_il), 38);
    checkOutput("acc_ql", $signed(acc_ql), 38);
    checkOutput("n_acc_il", $signed(n_acc_il), 38);
`endif

    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gps_correlator.md
Name: gps_correlator

Overview:
- Downstream consumer of the carrier NCO (1-bit sin/cos) and the C/A code generator (1-bit chip) in the GPS receiver front end.
- Per valid IF sample it wipes off carrier and code, then integrates signed ±1 products into I and Q accumulators.
- On each code epoch (1 ms C/A period) it dumps the totals to the tracking-loop processor through a valid/ready register.

Parameters:
- ACC_W, 16, accumulator/output width in bits, signed two's complement.
- CNT_W, 15, sample-count width.
- EL_DELAY, 8, samples between early, prompt and late code replicas; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sample_valid  in  1  qualifies if_sign, lo_sin, lo_cos, code_chip and epoch on this cycle.
- if_sign  in  1  1-bit IF sample.
- lo_sin  in  1  NCO sine output.
- lo_cos  in  1  NCO cosine output.
- code_chip  in  1  prompt C/A chip.
- epoch  in  1  this sample is the first of a new integration period.
- dump_ready  in  1  consumer accepts the dump.
- dump_valid  out  1  dump registers hold unconsumed data.
- acc_i  out  ACC_W  prompt in-phase total.
- acc_q  out  ACC_W  prompt quadrature total.
- dump_count  out  CNT_W  number of samples in the dumped period.
- overrun  out  1  sticky flag: a dump was overwritten before it was accepted.

Behaviour:
- Encoding: bit 0 = +1, bit 1 = −1.
  - Product bit: pi = if_sign ^ lo_cos ^ code_chip; pq = if_sign ^ lo_sin ^ code_chip.
  - Contribution: +1 when the product bit is 0, −1 when it is 1.
- Pipeline stage 1 (cycle N+1): register pi, pq, the sample's valid bit and the epoch&sample_valid bit.
- Pipeline stage 2 (cycle N+2): accumulate.
  - Epoch-qualified sample: the internal accumulator loads this sample's contribution (±1) and the count loads 1.
  - Previous totals and count go to acc_i, acc_q and dump_count; dump_valid goes to 1 at N+2.
- epoch is ignored when sample_valid=0. Cycles with sample_valid=0 change nothing.
- Saturation: accumulators clamp at +(2^(ACC_W−1)−1) and −(2^(ACC_W−1)); they never wrap. Count saturates at 2^CNT_W−1.
- Handshake:
  - A dump is accepted on a clk edge with dump_valid & dump_ready; dump_valid falls the next cycle unless a new dump lands on the same edge.
  - New dump and accept on the same edge: new data loads, dump_valid stays 1, no overrun.
  - New dump while dump_valid=1 and dump_ready=0: outputs are overwritten and overrun is set to 1. overrun clears only on rst.
- Reset (any cycle, including mid-integration):
  - Accumulators, count and pipeline registers clear. acc_i=0, acc_q=0, dump_count=0, dump_valid=0, overrun=0.
  - Samples before the first epoch after reset accumulate, and that first epoch dumps them.
- Output registers are stable while dump_valid=1 and no new dump lands.

Optional Feature:
- Macro GPS_CORR_EARLY_LATE_EN.
- Defined:
  - Adds output ports acc_ie, acc_qe, acc_il, acc_ql (ACC_W each).
  - Early chip = code_chip (current sample). Prompt = code_chip delayed EL_DELAY valid samples. Late = delayed 2·EL_DELAY valid samples, via a shift register advanced only on sample_valid.
  - In this mode acc_i/acc_q use the delayed prompt. All six arms share the epoch, saturation and dump handshake.
  - The delay line clears to 0 on rst.
- Undefined: only prompt arms exist and code_chip is used undelayed.

Decomposition:
- Package gps_corr_pkg:
  - Sign-encoding constants (POS=1'b0, NEG=1'b1).
  - ACC_W/CNT_W defaults.
  - Saturation limit functions.
- Sub-module corr_arm: one product-in accumulator with load-on-epoch and saturation. It is instantiated 2× (prompt) or 6× (early/late enabled).

Test Plan:
- All inputs 0 (lo_sin=1), 1000 valid samples, then epoch → acc_i=+1000, acc_q=−1000, dump_count=1000, dump_valid 2 cycles after the epoch sample.
- sample_valid toggled 1/0 for 400 cycles between epochs with if_sign alternating → acc_i=0, acc_q=0, dump_count=200.
- ACC_W=8, 300 samples all contributing +1 → acc_i=+127; all contributing −1 → acc_q=−128.
- dump_ready held 0 across two epochs → second dump visible, overrun=1. Then dump_ready=1 for one cycle → dump_valid=0, overrun stays 1.
- rst asserted after 500 samples, then 100 samples and epoch → dump_count=100, totals reflect only post-reset samples.
- GPS_CORR_EARLY_LATE_EN, EL_DELAY=8, code_chip=1 only on sample index 0, if_sign=lo_cos=0 → early/prompt/late each see one −1 chip on samples 0, 8 and 16 respectively; each arm's acc_i = N−2 for an N-sample epoch.
